// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1:N stream demultiplexer.
package demux_pkg;

  // What a channel's data register does once its word has been consumed.
  typedef enum logic {
    IDLE_HOLD = 1'b0,  // keep the last delivered word on the bus
    IDLE_ZERO = 1'b1   // clear the data register to zero
  } idle_mode_e;

  // Select width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  // Saturation value of a w-bit counter (all ones).
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/demux_1n_stream_if.sv
// Producer-side and consumer-side handshake bundle of the 1:N demultiplexer.
// The slave modport is the demultiplexer; the master modport is the
// producer plus the N consumers as seen from outside.
interface demux_1n_stream_if
  import demux_pkg::*;
#(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = clog2_min1(N_OUT)
);

  logic                      IN_VALID;
  logic                      IN_READY;
  logic [DATA_W-1:0]         IN;
  logic [SEL_W-1:0]          SL;
  logic [N_OUT*DATA_W-1:0]   OUT;
  logic [N_OUT-1:0]          OUT_VALID;
  logic [N_OUT-1:0]          OUT_READY;

  modport slave (
    input  IN_VALID, IN, SL, OUT_READY,
    output IN_READY, OUT, OUT_VALID
  );

  modport master (
    output IN_VALID, IN, SL, OUT_READY,
    input  IN_READY, OUT, OUT_VALID
  );

endinterface

// File: rtl/demux_chan_reg.sv
// One output channel: a single-entry data register with a valid flag.
// A load wins over a consume, so a word can be drained and replaced on the
// same edge and a busy channel streams at full rate.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int         DATA_W    = 1,
  parameter idle_mode_e IDLE_MODE = IDLE_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Load / consume / hold, in that priority.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset as well as the flag, so no word from
    // before a reset can ever reappear on the bus.
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
      if (IDLE_MODE == IDLE_ZERO) begin
        data <= '0;
      end
    end
  end

endmodule

// File: rtl/demux_1n_stream.sv
// Registered 1:N stream demultiplexer. The producer word is steered by SL
// into one of N_OUT independent single-entry channels; selects beyond the
// last channel are accepted, discarded and counted.
module demux_1n_stream
  import demux_pkg::*;
#(
  parameter int N_OUT     = 8,
  parameter int DATA_W    = 1,
  parameter int SEL_W     = clog2_min1(N_OUT),
  parameter int ZERO_IDLE = 1,
  parameter int CNT_W     = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  demux_1n_stream_if.slave   bus,
  output logic               DROP,
  output logic [CNT_W-1:0]   DROP_CNT
);

  localparam idle_mode_e       IDLE_MODE = (ZERO_IDLE != 0) ? IDLE_ZERO : IDLE_HOLD;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));

  logic [SEL_W-1:0]        sel;
  logic [N_OUT-1:0]        sel_hot;
  logic                    ch_free;
  logic                    in_xfer;
  logic                    drop_xfer;
  logic [N_OUT-1:0]        load;
  logic                    chan_valid [N_OUT];
  logic [DATA_W-1:0]       chan_data  [N_OUT];
  logic [N_OUT*DATA_W-1:0] out_flat;
  logic [N_OUT-1:0]        valid_flat;

  assign sel = bus.SL;

  // Decode the select and decide whether the addressed channel can take a
  // word; an out-of-range select matches no channel and is always accepted.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sel_hot = '0;
    ch_free = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (int'(sel) == k) begin
        sel_hot[k] = 1'b1;
        ch_free    = !bus.OUT_VALID[k] || bus.OUT_READY[k];
      end
    end
  end

  // Input transfer qualification: one channel load or one drop per cycle.
  always_comb begin
    in_xfer   = bus.IN_VALID && ch_free;
    load      = sel_hot & {N_OUT{in_xfer}};
    drop_xfer = in_xfer && (sel_hot == '0);
  end

  assign bus.IN_READY = ch_free;

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    demux_chan_reg #(
      .DATA_W    (DATA_W),
      .IDLE_MODE (IDLE_MODE)
    ) u_chan (
      .clk   (CLK),
      .rst_n (RST_N),
      .load  (load[k]),
      .din   (bus.IN),
      .ready (bus.OUT_READY[k]),
      .valid (chan_valid[k]),
      .data  (chan_data[k])
    );
  end

  // Flatten the per-channel registers onto the output bus.
  always_comb begin
    out_flat   = '0;
    valid_flat = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_flat[k*DATA_W +: DATA_W] = chan_data[k];
      valid_flat[k]                = chan_valid[k];
    end
  end

  assign bus.OUT       = out_flat;
  assign bus.OUT_VALID = valid_flat;

  // Drop pulse for the cycle after a discarded word, plus a saturating tally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DROP     <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      DROP <= drop_xfer;
      if (drop_xfer && (DROP_CNT != CNT_MAX)) begin
        DROP_CNT <= DROP_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1n_stream.sv
// Bench for demux_1n_stream. Three instances run side by side:
//   u0: N_OUT=8, DATA_W=1, ZERO_IDLE=1, CNT_W=8
//   u1: N_OUT=8, DATA_W=8, ZERO_IDLE=1, CNT_W=8
//   u2: N_OUT=6, DATA_W=8, ZERO_IDLE=0, CNT_W=2
// A behavioural model (per-channel slot arrays plus a drop tally) tracks all
// three on every edge.
module tb_demux_1n_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_1n_stream_if #(.N_OUT(8), .DATA_W(1)) if0 ();
  demux_1n_stream_if #(.N_OUT(8), .DATA_W(8)) if1 ();
  demux_1n_stream_if #(.N_OUT(6), .DATA_W(8)) if2 ();

  logic       drop0, drop1, drop2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  demux_1n_stream #(.N_OUT(8), .DATA_W(1), .ZERO_IDLE(1), .CNT_W(8)) u0 (
    .CLK(clk), .RST_N(rst_n), .bus(if0), .DROP(drop0), .DROP_CNT(cnt0));
  demux_1n_stream #(.N_OUT(8), .DATA_W(8), .ZERO_IDLE(1), .CNT_W(8)) u1 (
    .CLK(clk), .RST_N(rst_n), .bus(if1), .DROP(drop1), .DROP_CNT(cnt1));
  demux_1n_stream #(.N_OUT(6), .DATA_W(8), .ZERO_IDLE(0), .CNT_W(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .bus(if2), .DROP(drop2), .DROP_CNT(cnt2));

  int errors = 0;
  int checks = 0;

  // Instance configuration, as the model sees it.
  int nout  [3] = '{8, 8, 6};
  int dw    [3] = '{1, 8, 8};
  bit zidle [3] = '{1'b1, 1'b1, 1'b0};
  int cmax  [3] = '{255, 255, 3};

  // Model state.
  logic [7:0] m_data  [3][8];
  bit         m_valid [3][8];
  int         m_cnt   [3];
  bit         m_drop  [3];

  // Current stimulus per instance, and the stall bookkeeping for the
  // hold-stable producer rule.
  bit         cur_v   [3];
  logic [7:0] cur_d   [3];
  int         cur_sl  [3];
  logic [7:0] cur_rdy [3];
  bit         stalled [3];
  logic [7:0] held_d  [3];
  int         held_sl [3];

  // ---------------- model ----------------
  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_cnt[u]  = 0;
      m_drop[u] = 1'b0;
      stalled[u] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_data[u][k]  = 8'h00;
        m_valid[u][k] = 1'b0;
      end
    end
  endtask

  function automatic bit exp_ready(int u, int sl, logic [7:0] rdy);
    if (sl >= nout[u]) return 1'b1;
    return !m_valid[u][sl] || rdy[sl];
  endfunction

  // One clock edge: every slot the consumer takes empties, then the accepted
  // word (if any) lands in its slot or is counted as dropped.
  task automatic model_edge(int u, bit v, logic [7:0] d, int sl, logic [7:0] rdy);
    bit acc;
    acc = v && exp_ready(u, sl, rdy);
    m_drop[u] = acc && (sl >= nout[u]);
    for (int k = 0; k < nout[u]; k++) begin
      if (m_valid[u][k] && rdy[k]) begin
        m_valid[u][k] = 1'b0;
        if (zidle[u]) m_data[u][k] = 8'h00;
      end
    end
    if (acc && (sl < nout[u])) begin
      m_valid[u][sl] = 1'b1;
      m_data[u][sl]  = (dw[u] == 1) ? {7'b0, d[0]} : d;
    end
    if (m_drop[u] && (m_cnt[u] < cmax[u])) m_cnt[u]++;
  endtask

  function automatic logic [63:0] exp_out(int u);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < nout[u]; k++) e = e | (64'(m_data[u][k]) << (k * dw[u]));
    return e;
  endfunction

  function automatic logic [7:0] exp_valid(int u);
    logic [7:0] e;
    e = '0;
    for (int k = 0; k < nout[u]; k++) e[k] = m_valid[u][k];
    return e;
  endfunction

  // ---------------- DUT accessors ----------------
  function automatic logic [63:0] dut_out(int u);
    case (u)
      0:       return 64'(if0.OUT);
      1:       return 64'(if1.OUT);
      default: return 64'(if2.OUT);
    endcase
  endfunction

  function automatic logic [7:0] dut_valid(int u);
    case (u)
      0:       return 8'(if0.OUT_VALID);
      1:       return 8'(if1.OUT_VALID);
      default: return 8'(if2.OUT_VALID);
    endcase
  endfunction

  function automatic logic dut_ready(int u);
    case (u)
      0:       return if0.IN_READY;
      1:       return if1.IN_READY;
      default: return if2.IN_READY;
    endcase
  endfunction

  function automatic logic dut_drop(int u);
    case (u)
      0:       return drop0;
      1:       return drop1;
      default: return drop2;
    endcase
  endfunction

  function automatic int dut_cnt(int u);
    case (u)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(int u, bit v, logic [7:0] d, int sl);
    cur_v[u] = v; cur_d[u] = d; cur_sl[u] = sl;
    case (u)
      0: begin if0.IN_VALID = v; if0.IN = d[0]; if0.SL = 3'(sl); end
      1: begin if1.IN_VALID = v; if1.IN = d;    if1.SL = 3'(sl); end
      default: begin if2.IN_VALID = v; if2.IN = d; if2.SL = 3'(sl); end
    endcase
  endtask

  task automatic set_ready(int u, logic [7:0] r);
    cur_rdy[u] = r;
    case (u)
      0:       if0.OUT_READY = r;
      1:       if1.OUT_READY = r;
      default: if2.OUT_READY = r[5:0];
    endcase
  endtask

  // Advance one clock: confirm stalled inputs were held, update the model
  // with the pre-edge stimulus, then step to just after the rising edge.
  task automatic tick();
    #1;
    for (int u = 0; u < 3; u++) begin
      if (stalled[u]) begin
        checks++;
        if (!cur_v[u] || cur_d[u] !== held_d[u] || cur_sl[u] != held_sl[u]) begin
          errors++;
          $display("FAIL stall_hold u%0d: v=%0d d=%h sl=%0d required held d=%h sl=%0d",
                   u, cur_v[u], cur_d[u], cur_sl[u], held_d[u], held_sl[u]);
        end
      end
      stalled[u] = rst_n && cur_v[u] && !dut_ready(u);
      held_d[u]  = cur_d[u];
      held_sl[u] = cur_sl[u];
    end
    if (!rst_n) model_reset();
    else for (int u = 0; u < 3; u++) model_edge(u, cur_v[u], cur_d[u], cur_sl[u], cur_rdy[u]);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int u = 0; u < 3; u++) begin
      drive(u, 1'b0, 8'h00, 0);
      set_ready(u, 8'hFF);
    end
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int u = 0; u < 3; u++) begin
      drive(u, 1'b0, 8'h00, 3);
      set_ready(u, 8'hFF);
    end
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      checks++; if (dut_valid(u) !== 8'h00) begin errors++; $display("FAIL reset_valid u%0d: got %h required 00", u, dut_valid(u)); end
      checks++; if (dut_out(u) !== 64'h0) begin errors++; $display("FAIL reset_out u%0d: got %h required 0", u, dut_out(u)); end
      checks++; if (dut_drop(u) !== 1'b0 || dut_cnt(u) != 0) begin errors++; $display("FAIL reset_drop u%0d: drop=%b cnt=%0d required 0/0", u, dut_drop(u), dut_cnt(u)); end
      checks++; if (dut_ready(u) !== 1'b1) begin errors++; $display("FAIL reset_in_ready u%0d: got %b required 1", u, dut_ready(u)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int sl;
    set_ready(0, 8'hFF);
    for (int v = 0; v < 32; v++) begin
      sl = (v >> 1) & 7;
      drive(0, 1'b1, 8'(v & 1), sl);
      tick();
      checks++; if (dut_valid(0) !== (8'd1 << sl)) begin errors++; $display("FAIL sweep_valid v=%0d: got %h required %h", v, dut_valid(0), 8'd1 << sl); end
      checks++; if (dut_out(0) !== (64'(v & 1) << sl)) begin errors++; $display("FAIL sweep_out v=%0d: got %h required %h", v, dut_out(0), 64'(v & 1) << sl); end
      checks++; if (dut_drop(0) !== 1'b0) begin errors++; $display("FAIL sweep_drop v=%0d: got %b required 0", v, dut_drop(0)); end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    set_ready(1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      drive(1, 1'b1, d, 0);
      #1;
      checks++; if (dut_ready(1) !== 1'b1) begin errors++; $display("FAIL b2b_in_ready i=%0d: got %b required 1", i, dut_ready(1)); end
      tick();
      checks++; if (dut_out(1)[7:0] !== d || dut_valid(1)[0] !== 1'b1) begin errors++; $display("FAIL b2b_data i=%0d: got %h/%b required %h/1", i, dut_out(1)[7:0], dut_valid(1)[0], d); end
    end
    settle();
  endtask

  task automatic test_backpressure();
    set_ready(1, 8'hF7);
    drive(1, 1'b1, 8'hA5, 3);
    tick();
    drive(1, 1'b1, 8'h5A, 3);
    #1;
    checks++; if (dut_ready(1) !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b required 0", dut_ready(1)); end
    tick();
    tick();
    checks++; if (dut_out(1)[31:24] !== 8'hA5 || dut_valid(1)[3] !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b required a5/1", dut_out(1)[31:24], dut_valid(1)[3]); end
    set_ready(1, 8'hFF);
    #1;
    checks++; if (dut_ready(1) !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high: got %b required 1", dut_ready(1)); end
    tick();
    checks++; if (dut_out(1)[31:24] !== 8'h5A || dut_valid(1)[3] !== 1'b1) begin errors++; $display("FAIL bp_refill: got %h/%b required 5a/1", dut_out(1)[31:24], dut_valid(1)[3]); end
    drive(1, 1'b0, 8'h00, 0);
    tick();
    checks++; if (dut_valid(1) !== 8'h00 || dut_out(1) !== 64'h0) begin errors++; $display("FAIL bp_drain: got %h/%h required 00/0", dut_valid(1), dut_out(1)); end
    settle();
  endtask

  task automatic test_independence();
    set_ready(1, 8'hFB);
    drive(1, 1'b1, 8'h77, 2);
    tick();
    drive(1, 1'b1, 8'h11, 5);
    #1;
    checks++; if (dut_ready(1) !== 1'b1) begin errors++; $display("FAIL indep_in_ready: got %b required 1", dut_ready(1)); end
    tick();
    checks++; if (dut_out(1)[47:40] !== 8'h11 || dut_valid(1)[5] !== 1'b1) begin errors++; $display("FAIL indep_ch5: got %h/%b required 11/1", dut_out(1)[47:40], dut_valid(1)[5]); end
    checks++; if (dut_out(1)[23:16] !== 8'h77 || dut_valid(1)[2] !== 1'b1) begin errors++; $display("FAIL indep_ch2: got %h/%b required 77/1", dut_out(1)[23:16], dut_valid(1)[2]); end
    settle();
  endtask

  task automatic test_drop();
    int want;
    set_ready(2, 8'h3F);
    for (int i = 0; i < 5; i++) begin
      drive(2, 1'b1, 8'($urandom), 7);
      tick();
      want = (i + 1 < 3) ? i + 1 : 3;
      checks++; if (dut_drop(2) !== 1'b1 || dut_cnt(2) != want) begin errors++; $display("FAIL drop_pulse i=%0d: drop=%b cnt=%0d required 1/%0d", i, dut_drop(2), dut_cnt(2), want); end
      checks++; if (dut_valid(2) !== 8'h00) begin errors++; $display("FAIL drop_no_chan i=%0d: got %h required 00", i, dut_valid(2)); end
    end
    drive(2, 1'b0, 8'h00, 0);
    tick();
    checks++; if (dut_drop(2) !== 1'b0 || dut_cnt(2) != 3) begin errors++; $display("FAIL drop_idle: drop=%b cnt=%0d required 0/3", dut_drop(2), dut_cnt(2)); end
    drive(2, 1'b1, 8'h42, 0);
    tick();
    checks++; if (dut_valid(2) !== 8'h01 || dut_out(2)[7:0] !== 8'h42 || dut_drop(2) !== 1'b0) begin errors++; $display("FAIL drop_then_deliver: got %h/%h/%b required 01/42/0", dut_valid(2), dut_out(2)[7:0], dut_drop(2)); end
    settle();
  endtask

  task automatic test_zero_idle();
    set_ready(1, 8'hEF);
    set_ready(2, 8'h2F);
    drive(1, 1'b1, 8'h3C, 4);
    drive(2, 1'b1, 8'h3C, 4);
    tick();
    checks++; if (dut_valid(1)[4] !== 1'b1 || dut_valid(2)[4] !== 1'b1) begin errors++; $display("FAIL zi_loaded: got %b/%b required 1/1", dut_valid(1)[4], dut_valid(2)[4]); end
    drive(1, 1'b0, 8'h00, 0);
    drive(2, 1'b0, 8'h00, 0);
    set_ready(1, 8'hFF);
    set_ready(2, 8'h3F);
    tick();
    checks++; if (dut_out(1)[39:32] !== 8'h00 || dut_valid(1)[4] !== 1'b0) begin errors++; $display("FAIL zi_zero: got %h/%b required 00/0", dut_out(1)[39:32], dut_valid(1)[4]); end
    checks++; if (dut_out(2)[39:32] !== 8'h3C || dut_valid(2)[4] !== 1'b0) begin errors++; $display("FAIL zi_hold: got %h/%b required 3c/0", dut_out(2)[39:32], dut_valid(2)[4]); end
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int u = 1; u < 3; u++) begin
        if (!stalled[u]) drive(u, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7));
        set_ready(u, 8'($urandom));
      end
      #1;
      for (int u = 1; u < 3; u++) begin
        checks++; if (dut_ready(u) !== exp_ready(u, cur_sl[u], cur_rdy[u])) begin errors++; $display("FAIL rand_in_ready u%0d c=%0d: got %b required %b", u, c, dut_ready(u), exp_ready(u, cur_sl[u], cur_rdy[u])); end
      end
      tick();
      for (int u = 0; u < 3; u++) begin
        checks++; if (dut_valid(u) !== exp_valid(u)) begin errors++; $display("FAIL rand_valid u%0d c=%0d: got %h required %h", u, c, dut_valid(u), exp_valid(u)); end
        checks++; if (dut_out(u) !== exp_out(u)) begin errors++; $display("FAIL rand_out u%0d c=%0d: got %h required %h", u, c, dut_out(u), exp_out(u)); end
        checks++; if (dut_drop(u) !== m_drop[u] || dut_cnt(u) != m_cnt[u]) begin errors++; $display("FAIL rand_drop u%0d c=%0d: got %b/%0d required %b/%0d", u, c, dut_drop(u), dut_cnt(u), m_drop[u], m_cnt[u]); end
      end
    end
    settle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    set_ready(1, 8'hBD);
    drive(1, 1'b1, 8'($urandom), 1);
    drive(2, 1'b1, 8'h00, 7);
    tick();
    drive(1, 1'b1, 8'($urandom), 6);
    tick();
    drive(1, 1'b0, 8'h00, 0);
    drive(2, 1'b0, 8'h00, 0);
    checks++; if (dut_valid(1) !== 8'h42 || dut_cnt(2) != 2) begin errors++; $display("FAIL areset_setup: valid=%h cnt=%0d required 42/2", dut_valid(1), dut_cnt(2)); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++; if (dut_valid(u) !== 8'h00 || dut_out(u) !== 64'h0) begin errors++; $display("FAIL areset_clear u%0d: valid=%h out=%h required 00/0", u, dut_valid(u), dut_out(u)); end
      checks++; if (dut_cnt(u) != 0 || dut_drop(u) !== 1'b0) begin errors++; $display("FAIL areset_cnt u%0d: cnt=%0d drop=%b required 0/0", u, dut_cnt(u), dut_drop(u)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (dut_valid(1) !== exp_valid(1) || dut_out(1) !== exp_out(1)) begin errors++; $display("FAIL areset_after: valid=%h out=%h required %h/%h", dut_valid(1), dut_out(1), exp_valid(1), exp_out(1)); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_backpressure();
    test_independence();
    test_drop();
    test_zero_idle();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
